// File: rtl/vector_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : vector_serial_alu
//  Description : Element-serial vector execute stage. Latches two operand
//                vectors (or one vector and a scalar), runs one SEW-bit
//                element per cycle through a small ALU into a result buffer,
//                then issues a one-cycle register file writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_serial_alu #(
  parameter int VL  = 8,
  parameter int SEW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        op,
  input  logic              use_scalar,
  input  logic [SEW-1:0]    scalar,
  input  logic [VL*SEW-1:0] vs1_data,
  input  logic [VL*SEW-1:0] vs2_data,
  input  logic [4:0]        vd_addr_in,
  output logic              busy,
  output logic              done,
  output logic              wb_write,
  output logic [4:0]        wb_vd_addr,
  output logic [VL*SEW-1:0] wb_data
);

  localparam int IDXW = (VL > 1) ? $clog2(VL) : 1;
  localparam int SHW  = (SEW > 1) ? $clog2(SEW) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(VL - 1);

  localparam logic [2:0] C_OP_ADD = 3'd0;
  localparam logic [2:0] C_OP_SUB = 3'd1;
  localparam logic [2:0] C_OP_AND = 3'd2;
  localparam logic [2:0] C_OP_OR  = 3'd3;
  localparam logic [2:0] C_OP_XOR = 3'd4;
  localparam logic [2:0] C_OP_SLL = 3'd5;
  localparam logic [2:0] C_OP_SRL = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDXW-1:0]     idx_q;
  logic [2:0]          op_q;
  logic                use_scalar_q;
  logic [SEW-1:0]      scalar_q;
  logic [VL*SEW-1:0]   vs1_q;
  logic [VL*SEW-1:0]   vs2_q;
  logic                busy_q;
  logic                done_q;
  logic                wb_write_q;
  logic [4:0]          wb_vd_addr_q;
  logic [VL*SEW-1:0]   wb_data_q;

  logic [SEW-1:0]      a_d;
  logic [SEW-1:0]      b_d;
  logic [SEW-1:0]      elem_d;

  // Current element operands from the latched copies: a from vs2, b from vs1 or the scalar.
  always_comb begin
    a_d = vs2_q[int'(idx_q)*SEW +: SEW];
    b_d = use_scalar_q ? scalar_q : vs1_q[int'(idx_q)*SEW +: SEW];
  end

  // Element ALU; shifts use only the low log2(SEW) bits of b, MIN keeps a on a tie.
  always_comb begin
    elem_d = '0;
    case (op_q)
      C_OP_ADD: elem_d = a_d + b_d;
      C_OP_SUB: elem_d = a_d - b_d;
      C_OP_AND: elem_d = a_d & b_d;
      C_OP_OR:  elem_d = a_d | b_d;
      C_OP_XOR: elem_d = a_d ^ b_d;
      C_OP_SLL: elem_d = a_d << b_d[SHW-1:0];
      C_OP_SRL: elem_d = a_d >> b_d[SHW-1:0];
      default:  elem_d = ($signed(b_d) < $signed(a_d)) ? b_d : a_d;
    endcase
  end

  // Control FSM with registered outputs; the result buffer is wb_data itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wb_write_q   <= 1'b0;
      wb_vd_addr_q <= '0;
      wb_data_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      wb_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // kill takes priority over a simultaneous start
          if (start && !kill) begin
            op_q         <= op;
            use_scalar_q <= use_scalar;
            scalar_q     <= scalar;
            vs1_q        <= vs1_data;
            vs2_q        <= vs2_data;
            wb_vd_addr_q <= vd_addr_in;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wb_data_q[int'(idx_q)*SEW +: SEW] <= elem_d;
            idx_q <= idx_q + 1'b1;
            if (idx_q == C_LAST_IDX) begin
              wb_write_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= S_WB;
            end
          end
        end
        S_WB: begin
          // writeback cycle: kill and start are both ignored here
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wb_write   = wb_write_q;
  assign wb_vd_addr = wb_vd_addr_q;
  assign wb_data    = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_serial_alu
//  Description : Self-checking bench for vector_serial_alu: directed vector
//                table, randomized ops against a reference model, and
//                hand-written kill / reset / back-to-back timing sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_serial_alu;

  localparam int VL  = 8;
  localparam int SEW = 32;
  localparam int W   = VL * SEW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          kill = 1'b0;
  logic [2:0]    op = '0;
  logic          use_scalar = 1'b0;
  logic [SEW-1:0] scalar = '0;
  logic [W-1:0]  vs1_data = '0;
  logic [W-1:0]  vs2_data = '0;
  logic [4:0]    vd_addr_in = '0;
  logic          busy;
  logic          done;
  logic          wb_write;
  logic [4:0]    wb_vd_addr;
  logic [W-1:0]  wb_data;

  int errors = 0;
  int checks = 0;

  vector_serial_alu #(.VL(VL), .SEW(SEW)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .use_scalar(use_scalar), .scalar(scalar), .vs1_data(vs1_data),
    .vs2_data(vs2_data), .vd_addr_in(vd_addr_in), .busy(busy), .done(done),
    .wb_write(wb_write), .wb_vd_addr(wb_vd_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic           us;
    logic [SEW-1:0] sc;
    logic [W-1:0]   vs1;
    logic [W-1:0]   vs2;
    logic [4:0]     vd;
    logic [W-1:0]   exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ramp(input logic [SEW-1:0] base, input logic [SEW-1:0] step);
    logic [W-1:0] v;
    for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = base + step * SEW'(i);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = $urandom;
    return v;
  endfunction

  // Reference: element-wise arithmetic straight from the operation definitions.
  function automatic logic [SEW-1:0] ref_elem(input logic [2:0] o, input logic [SEW-1:0] a,
                                               input logic [SEW-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return SEW'(longint'(a) + longint'(b));
      3'd1: return SEW'(longint'(a) - longint'(b));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % SEW);
      3'd6: return a >> (b % SEW);
      default: return (sa <= sb) ? a : b;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_vec(input vec_t t);
    logic [W-1:0] r;
    for (int i = 0; i < VL; i++)
      r[i*SEW +: SEW] = ref_elem(t.op, t.vs2[i*SEW +: SEW], t.us ? t.sc : t.vs1[i*SEW +: SEW]);
    return r;
  endfunction

  task automatic drive(input vec_t t);
    op = t.op; use_scalar = t.us; scalar = t.sc;
    vs1_data = t.vs1; vs2_data = t.vs2; vd_addr_in = t.vd;
  endtask

  // Pulse start for one edge (edge T), then scramble the operand inputs.
  task automatic issue(input vec_t t);
    @(negedge clk);
    drive(t);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); use_scalar = 1'($urandom); scalar = $urandom;
    vs1_data = rand_vec(); vs2_data = rand_vec(); vd_addr_in = 5'($urandom);
  endtask

  // Full op: writeback exactly once, in cycle T+9, with correct data/address.
  task automatic run_check(input string name, input vec_t t);
    int first = -1;
    int n = 0;
    issue(t);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) chk({name, "_busy"}, W'(busy), W'(1));
      if (wb_write) begin
        n++; first = k;
        chk({name, "_done"}, W'(done), W'(1));
      end
    end
    chk({name, "_lat"}, W'(first), W'(9));
    chk({name, "_npulse"}, W'(n), W'(1));
    chk({name, "_data"}, wb_data, t.exp);
    chk({name, "_vd"}, W'(wb_vd_addr), W'(t.vd));
  endtask

  initial begin
    vec_t r;
    int   first, n;
    int   wbq[$];

    tbl[0] = '{op:3'd0, us:1'b0, sc:'0, vs1:ramp(10, 1), vs2:ramp(0, 1), vd:5'd3, exp:ramp(10, 2)};
    tbl[1] = '{op:3'd1, us:1'b0, sc:'0, vs1:ramp(1, 0), vs2:ramp(0, 0), vd:5'd4, exp:ramp(32'hFFFF_FFFF, 0)};
    tbl[2] = '{op:3'd7, us:1'b0, sc:'0, vs1:ramp(5, 0), vs2:ramp(32'h8000_0000, 0), vd:5'd5, exp:ramp(32'h8000_0000, 0)};
    tbl[3] = '{op:3'd5, us:1'b1, sc:32'h21, vs1:ramp(32'h1234_5678, 7), vs2:ramp(1, 0), vd:5'd6, exp:ramp(2, 0)};
    tbl[4] = '{op:3'd6, us:1'b0, sc:'0, vs1:ramp(31, 0), vs2:ramp(32'h8000_0000, 0), vd:5'd7, exp:ramp(1, 0)};
    tbl[5] = '{op:3'd7, us:1'b0, sc:'0, vs1:ramp(32'hFFFF_FFFD, 0), vs2:ramp(5, 0), vd:5'd8, exp:ramp(32'hFFFF_FFFD, 0)};
    tbl[6] = '{op:3'd2, us:1'b0, sc:'0, vs1:ramp(32'hFF00_FF00, 0), vs2:ramp(32'hF0F0_F0F0, 0), vd:5'd9, exp:ramp(32'hF000_F000, 0)};
    tbl[7] = '{op:3'd4, us:1'b0, sc:'0, vs1:ramp(32'hFFFF_FFFF, 0), vs2:ramp(0, 1), vd:5'd10, exp:ramp(32'hFFFF_FFFF, 32'hFFFF_FFFF)};
    tbl[8] = '{op:3'd3, us:1'b1, sc:32'hF0, vs1:ramp(0, 0), vs2:ramp(32'h0F, 0), vd:5'd31, exp:ramp(32'hFF, 0)};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_busy", W'(busy), W'(0));
      chk("idle_done", W'(done), W'(0));
      chk("idle_wb", W'(wb_write), W'(0));
    end
    chk("rst_data", wb_data, '0);
    chk("rst_vd", W'(wb_vd_addr), W'(0));

    // Directed table
    for (int i = 0; i < 9; i++) run_check($sformatf("tbl%0d", i), tbl[i]);

    // Randomized ops against the reference model
    for (int i = 0; i < 20; i++) begin
      r.op = 3'($urandom); r.us = 1'($urandom); r.sc = $urandom;
      r.vs1 = rand_vec(); r.vs2 = rand_vec(); r.vd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r.vs1 = r.vs2;
      r.exp = ref_vec(r);
      run_check($sformatf("rnd%0d", i), r);
    end

    // kill at T+4, restart at T+6 -> writeback only at T+15
    issue(tbl[6]);
    first = -1; n = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (wb_write) begin n++; first = k; end
      if (k == 4) kill = 1'b1;
      if (k == 5) begin
        kill = 1'b0;
        chk("kill_busy", W'(busy), W'(0));
      end
      if (k == 6) begin drive(tbl[0]); vd_addr_in = 5'd9; start = 1'b1; end
      if (k == 7) start = 1'b0;
    end
    chk("kill_first", W'(first), W'(15));
    chk("kill_npulse", W'(n), W'(1));
    chk("kill_data", wb_data, tbl[0].exp);
    chk("kill_vd", W'(wb_vd_addr), W'(9));

    // kill together with start in IDLE: start is dropped
    @(negedge clk);
    drive(tbl[1]); start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", W'(busy), W'(0));

    // start held high: writebacks every VL+2 cycles
    r = tbl[7];
    @(negedge clk);
    drive(r); start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wb_write) begin
        wbq.push_back(k);
        chk("held_data", wb_data, r.exp);
      end
    end
    start = 1'b0;
    chk("held_count", W'(wbq.size()), W'(4));
    for (int i = 1; i < wbq.size(); i++)
      chk("held_period", W'(wbq[i] - wbq[i-1]), W'(VL + 2));
    repeat (12) @(negedge clk);

    // start pulse during the WB cycle is ignored
    issue(tbl[2]);
    n = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (wb_write) n++;
      if (k == 9) start = 1'b1;
      if (k == 10) begin
        start = 1'b0;
        chk("wbstart_busy", W'(busy), W'(0));
      end
    end
    chk("wbstart_npulse", W'(n), W'(1));

    // rst mid-operation at T+3
    issue(tbl[3]);
    n = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (wb_write || done) n++;
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        rst = 1'b0;
        chk("rstmid_busy", W'(busy), W'(0));
        chk("rstmid_data", wb_data, '0);
        chk("rstmid_vd", W'(wb_vd_addr), W'(0));
      end
    end
    chk("rstmid_nowb", W'(n), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
